sha1_job_sched: RTL and testbench

Job scheduler that sequences hash requests through a single `sha1` core. Software-side requesters push job descriptors (message address, byte size, output address, tag) into a small queue. The scheduler launches the core one job at a time, detects completion or timeout, and returns a tagged completion record with a cycle count. It sits between the host/requester logic and the `sha1` core's `start`/`done` control interface; the core's memory port is untouched.

---
 rtl/sha1_sched_pkg.sv | 27 ++
 rtl/sha1_job_sched_if.sv | 38 +++
 rtl/sha1_job_fifo.sv | 48 ++++
 rtl/sha1_job_sched.sv | 152 +++++++++++++++
 tb/tb_sha1_job_sched.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_sched_pkg.sv
// Shared types for the SHA-1 job scheduler: job descriptor, completion status
// and scheduler FSM states.
package sha1_sched_pkg;

  localparam int unsigned JOB_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          message_addr;
    logic [31:0]          size;
    logic [31:0]          output_addr;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_REJECTED = 2'b10
  } cmp_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_REPORT
  } sched_state_e;

endpackage

// File: rtl/sha1_job_sched_if.sv
// Requester, core-control and completion signals of the job scheduler.
// The slave modport is the scheduler side, master is the host/core side.
interface sha1_job_sched_if #(
  parameter int unsigned TAG_W = 4
);
  logic             job_valid;
  logic             job_ready;
  logic [31:0]      job_message_addr;
  logic [31:0]      job_size;
  logic [31:0]      job_output_addr;
  logic [TAG_W-1:0] job_tag;

  logic             core_start;
  logic [31:0]      core_message_addr;
  logic [31:0]      core_size;
  logic [31:0]      core_output_addr;
  logic             core_done;

  logic             cmp_valid;
  logic             cmp_ready;
  logic [TAG_W-1:0] cmp_tag;
  logic [1:0]       cmp_status;
  logic [31:0]      cmp_cycles;

  modport slave (
    input  job_valid, job_message_addr, job_size, job_output_addr, job_tag,
    input  core_done, cmp_ready,
    output job_ready, core_start, core_message_addr, core_size, core_output_addr,
    output cmp_valid, cmp_tag, cmp_status, cmp_cycles
  );

  modport master (
    output job_valid, job_message_addr, job_size, job_output_addr, job_tag,
    output core_done, cmp_ready,
    input  job_ready, core_start, core_message_addr, core_size, core_output_addr,
    input  cmp_valid, cmp_tag, cmp_status, cmp_cycles
  );
endinterface

// File: rtl/sha1_job_fifo.sv
// Job descriptor FIFO; pointers carry an extra wrap bit to tell full from empty.
module sha1_job_fifo
  import sha1_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  job_t i_data,
  output logic o_full,
  input  logic i_pop,
  output job_t o_data,
  output logic o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  job_t       r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/sha1_job_sched.sv
// Sequences queued hash jobs through one sha1 core: launch, wait for a done
// rise or timeout, then hold a tagged completion record until accepted.
module sha1_job_sched
  import sha1_sched_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = JOB_TAG_W,
  parameter logic [31:0] MAX_SIZE = 32'd65536,
  parameter logic [31:0] TIMEOUT  = 32'd200000
) (
  input logic             clk,
  input logic             reset_n,
  sha1_job_sched_if.slave bus
);
  sched_state_e          r_state;
  sched_state_e          w_next_state;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  job_t                  w_in_job;
  job_t                  w_head;
  logic                  w_legal;
  logic                  w_rise;
  logic                  w_timeout;
  logic                  w_core_start;
  logic                  w_cmp_valid;

  logic                  r_done_q;
  logic [31:0]           r_counter;
  logic [31:0]           r_core_message_addr;
  logic [31:0]           r_core_size;
  logic [31:0]           r_core_output_addr;
  logic [JOB_TAG_W-1:0]  r_cmp_tag;
  cmp_status_e           r_cmp_status;
  logic [31:0]           r_cmp_cycles;

  assign w_push = bus.job_valid && !w_full;

  always_comb begin
    w_in_job              = '0;
    w_in_job.message_addr = bus.job_message_addr;
    w_in_job.size         = bus.job_size;
    w_in_job.output_addr  = bus.job_output_addr;
    w_in_job.tag          = JOB_TAG_W'(bus.job_tag);
  end

  sha1_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_in_job),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  assign w_legal   = (w_head.size != 32'd0) && (w_head.size <= MAX_SIZE);
  // Only a rising done completes a job; a level left over from the previous job is ignored.
  assign w_rise    = bus.core_done && !r_done_q;
  assign w_timeout = (r_counter == TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_core_start = 1'b0;
    w_cmp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = w_legal ? S_LAUNCH : S_REPORT;
        end
      end
      S_LAUNCH: begin
        w_core_start = 1'b1;
        w_next_state = S_BUSY;
      end
      S_BUSY: begin
        if (w_rise || w_timeout) w_next_state = S_REPORT;
      end
      S_REPORT: begin
        w_cmp_valid = 1'b1;
        if (bus.cmp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counter reads 1 during LAUNCH, so a done seen k cycles after launch reports k+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_q            <= 1'b0;
      r_counter           <= '0;
      r_core_message_addr <= '0;
      r_core_size         <= '0;
      r_core_output_addr  <= '0;
      r_cmp_tag           <= '0;
      r_cmp_status        <= ST_OK;
      r_cmp_cycles        <= '0;
    end else begin
      r_done_q <= bus.core_done;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cmp_tag <= w_head.tag;
            if (w_legal) begin
              r_core_message_addr <= w_head.message_addr;
              r_core_size         <= w_head.size;
              r_core_output_addr  <= w_head.output_addr;
              r_counter           <= 32'd1;
            end else begin
              r_cmp_status <= ST_REJECTED;
              r_cmp_cycles <= '0;
            end
          end
        end
        S_LAUNCH: r_counter <= r_counter + 32'd1;
        S_BUSY: begin
          r_counter <= r_counter + 32'd1;
          if (w_rise) begin
            r_cmp_status <= ST_OK;
            r_cmp_cycles <= r_counter;
          end else if (w_timeout) begin
            r_cmp_status <= ST_TIMEOUT;
            r_cmp_cycles <= TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.job_ready         = !w_full;
  assign bus.core_start        = w_core_start;
  assign bus.core_message_addr = r_core_message_addr;
  assign bus.core_size         = r_core_size;
  assign bus.core_output_addr  = r_core_output_addr;
  assign bus.cmp_valid         = w_cmp_valid;
  assign bus.cmp_tag           = TAG_W'(r_cmp_tag);
  assign bus.cmp_status        = r_cmp_status;
  assign bus.cmp_cycles        = r_cmp_cycles;

endmodule

// File: tb/tb_sha1_job_sched.sv
// Directed bench for sha1_job_sched: table of single jobs plus sequences for
// queue fill, timeout, done held high and reset during a job.
module tb_sha1_job_sched;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;
  int   start_cnt;

  sha1_job_sched_if #(.TAG_W(4)) bus   ();
  sha1_job_sched_if #(.TAG_W(4)) bus_t ();

  sha1_job_sched #(
    .DEPTH (4), .TAG_W (4), .MAX_SIZE (32'd65536), .TIMEOUT (32'd200000)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .bus (bus)
  );

  sha1_job_sched #(
    .DEPTH (4), .TAG_W (4), .MAX_SIZE (32'd65536), .TIMEOUT (32'd100)
  ) u_dut_to (
    .clk (clk), .reset_n (reset_n), .bus (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)            start_cnt <= 0;
    else if (bus.core_start) start_cnt <= start_cnt + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] size;
    logic [31:0] out;
    logic [3:0]  tag;
    int          delay;
    logic [1:0]  st;
    logic [31:0] cyc;
    bit          start;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] o,
                      input logic [3:0] t, output bit acc);
    @(negedge clk);
    bus.job_valid        = 1'b1;
    bus.job_message_addr = a;
    bus.job_size         = s;
    bus.job_output_addr  = o;
    bus.job_tag          = t;
    acc = bus.job_ready;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
  endtask

  // Negedges until core_start or cmp_valid; -1 if neither within lim.
  task automatic wait_evt(input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (bus.core_start || bus.cmp_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_cmp(input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (bus.cmp_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic consume(input bit drop_done);
    bus.cmp_ready = 1'b1;
    @(posedge clk);
    #1 bus.cmp_ready = 1'b0;
    if (drop_done) bus.core_done = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    int s0;
    bit stable;
    bit exp_acc;

    n_checks = 0;
    n_err    = 0;
    vecs[0] = '{addr: 32'd0,     size: 32'd120,   out: 32'd30,  tag: 4'd3, delay: 500,
                st: 2'b00, cyc: 32'd501, start: 1'b1};
    vecs[1] = '{addr: 32'd4,     size: 32'd0,     out: 32'd8,   tag: 4'd5, delay: 0,
                st: 2'b10, cyc: 32'd0,   start: 1'b0};
    vecs[2] = '{addr: 32'd5,     size: 32'd65537, out: 32'd9,   tag: 4'd6, delay: 0,
                st: 2'b10, cyc: 32'd0,   start: 1'b0};
    vecs[3] = '{addr: 32'h1000,  size: 32'd65536, out: 32'h2000, tag: 4'd7, delay: 3,
                st: 2'b00, cyc: 32'd4,   start: 1'b1};
    vecs[4] = '{addr: 32'h3000,  size: 32'd1,     out: 32'h4000, tag: 4'd8, delay: 1,
                st: 2'b00, cyc: 32'd2,   start: 1'b1};

    reset_n = 1'b1;
    bus.job_valid = 1'b0; bus.job_message_addr = '0; bus.job_size = '0;
    bus.job_output_addr = '0; bus.job_tag = '0; bus.core_done = 1'b0; bus.cmp_ready = 1'b0;
    bus_t.job_valid = 1'b0; bus_t.job_message_addr = '0; bus_t.job_size = '0;
    bus_t.job_output_addr = '0; bus_t.job_tag = '0; bus_t.core_done = 1'b0;
    bus_t.cmp_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst job_ready", {31'd0, bus.job_ready}, 32'd1);
    chk("rst core_start", {31'd0, bus.core_start}, 32'd0);
    chk("rst cmp_valid", {31'd0, bus.cmp_valid}, 32'd0);
    chk("rst core_size", bus.core_size, 32'd0);
    chk("rst cmp_cycles", bus.cmp_cycles, 32'd0);
    reset_n = 1'b1;

    // Table: single jobs, legal and illegal sizes
    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      push(vecs[i].addr, vecs[i].size, vecs[i].out, vecs[i].tag, acc);
      chk("vec accepted", {31'd0, acc}, 32'd1);
      wait_evt(10, k);
      chk("vec first event latency", k, 32'd2);
      if (vecs[i].start) begin
        chk("vec core_start", {31'd0, bus.core_start}, 32'd1);
        chk("vec core_message_addr", bus.core_message_addr, vecs[i].addr);
        chk("vec core_size", bus.core_size, vecs[i].size);
        chk("vec core_output_addr", bus.core_output_addr, vecs[i].out);
        repeat (vecs[i].delay) @(posedge clk);
        #1 bus.core_done = 1'b1;
        wait_cmp(4, k);
        chk("vec cmp latency", k, 32'd2);
      end else begin
        chk("vec reject cmp_valid", {31'd0, bus.cmp_valid}, 32'd1);
      end
      chk("vec cmp_tag", {28'd0, bus.cmp_tag}, {28'd0, vecs[i].tag});
      chk("vec cmp_status", {30'd0, bus.cmp_status}, {30'd0, vecs[i].st});
      chk("vec cmp_cycles", bus.cmp_cycles, vecs[i].cyc);
      chk("vec start count", start_cnt - s0, {31'd0, vecs[i].start});
      consume(1'b1);
    end

    // Fill the queue while the core is busy
    push(32'd100, 32'd64, 32'd200, 4'd1, acc);
    wait_evt(10, k);
    chk("fill launch A", k, 32'd2);
    for (int j = 0; j < 5; j++) begin
      exp_acc = (j < 4);
      push(32'd100 + j, 32'd64, 32'd300 + j, 4'(j + 2), acc);
      chk("fill accept", {31'd0, acc}, {31'd0, exp_acc});
    end
    chk("fill job_ready full", {31'd0, bus.job_ready}, 32'd0);
    @(posedge clk);
    #1 bus.core_done = 1'b1;
    wait_cmp(4, k);
    chk("fill cmp A latency", k, 32'd2);
    chk("fill cmp A tag", {28'd0, bus.cmp_tag}, 32'd1);
    consume(1'b1);
    for (int t = 2; t <= 5; t++) begin
      wait_evt(10, k);
      chk("b2b launch latency", k, 32'd2);
      chk("b2b core_output_addr", bus.core_output_addr, 32'd300 + 32'(t - 2));
      repeat (2) @(posedge clk);
      #1 bus.core_done = 1'b1;
      wait_cmp(4, k);
      chk("fill cmp order tag", {28'd0, bus.cmp_tag}, t);
      chk("fill cmp status", {30'd0, bus.cmp_status}, 32'd0);
      chk("fill cmp cycles", bus.cmp_cycles, 32'd3);
      consume(1'b1);
    end
    wait_evt(10, k);
    chk("fill dropped job absent", k, 32'hffffffff);
    chk("fill job_ready drained", {31'd0, bus.job_ready}, 32'd1);

    // core_done held high across jobs
    push(32'd50, 32'd16, 32'd60, 4'd9, acc);
    wait_evt(10, k);
    chk("held launch X", k, 32'd2);
    repeat (5) @(posedge clk);
    #1 bus.core_done = 1'b1;
    wait_cmp(4, k);
    chk("held cmp X cycles", bus.cmp_cycles, 32'd6);
    consume(1'b0);
    push(32'd51, 32'd16, 32'd61, 4'd10, acc);
    wait_evt(10, k);
    chk("held launch Y", {31'd0, bus.core_start}, 32'd1);
    wait_cmp(20, k);
    chk("held level no complete", k, 32'hffffffff);
    @(posedge clk);
    #1 bus.core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.core_done = 1'b1;
    wait_cmp(4, k);
    chk("held rise latency", k, 32'd2);
    chk("held cmp Y tag", {28'd0, bus.cmp_tag}, 32'd10);
    chk("held cmp Y cycles", bus.cmp_cycles, 32'd25);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 4'd10 ||
          bus.cmp_cycles !== 32'd25 || bus.cmp_status !== 2'b00) stable = 1'b0;
    end
    chk("held record stable", {31'd0, stable}, 32'd1);
    consume(1'b1);

    // Timeout instance: core never answers
    @(negedge clk);
    bus_t.job_valid = 1'b1; bus_t.job_size = 32'd8; bus_t.job_tag = 4'd11;
    bus_t.job_message_addr = 32'd7; bus_t.job_output_addr = 32'd9;
    @(posedge clk);
    #1 bus_t.job_valid = 1'b0;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_t.core_start) begin k = i; break; end
    end
    chk("to launch latency", k, 32'd2);
    k = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (bus_t.cmp_valid) begin k = i; break; end
    end
    chk("to report cycle", k, 32'd100);
    chk("to status", {30'd0, bus_t.cmp_status}, 32'd1);
    chk("to cycles", bus_t.cmp_cycles, 32'd100);
    chk("to tag", {28'd0, bus_t.cmp_tag}, 32'd11);
    bus_t.cmp_ready = 1'b1;
    @(posedge clk);
    #1 bus_t.cmp_ready = 1'b0;
    @(negedge clk);
    bus_t.job_valid = 1'b1; bus_t.job_tag = 4'd12;
    @(posedge clk);
    #1 bus_t.job_valid = 1'b0;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_t.core_start) begin k = i; break; end
    end
    chk("to next launch", k, 32'd2);

    // Reset during BUSY with one job queued behind
    push(32'd70, 32'd32, 32'd80, 4'd12, acc);
    wait_evt(10, k);
    chk("rst launch", k, 32'd2);
    push(32'd71, 32'd32, 32'd81, 4'd13, acc);
    chk("rst queued accept", {31'd0, acc}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst core_start", {31'd0, bus.core_start}, 32'd0);
    chk("midrst core_size", bus.core_size, 32'd0);
    chk("midrst core_message_addr", bus.core_message_addr, 32'd0);
    chk("midrst cmp_tag", {28'd0, bus.cmp_tag}, 32'd0);
    chk("midrst cmp_cycles", bus.cmp_cycles, 32'd0);
    chk("midrst cmp_valid", {31'd0, bus.cmp_valid}, 32'd0);
    chk("midrst job_ready", {31'd0, bus.job_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_evt(20, k);
    chk("postrst queue empty", k, 32'hffffffff);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
